// File: rtl/uart_ram_pkg.sv
// Shared types and helpers for the UART-accessible RAM controller.
// Holds op codes, response bytes, FSM state encodings and byte-count sizing.
package uart_ram_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  localparam logic [7:0] ACK_BYTE = 8'hA5;
  localparam logic [7:0] NAK_BYTE = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_WR,
    ST_ACK,
    ST_RD,
    ST_TXW
  } state_t;

  typedef enum logic [1:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP
  } bit_state_t;

  // Number of whole bytes needed to carry a field of the given width.
  function automatic int nbytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_byte.sv
// 8N1 UART byte engines: a mid-bit sampling receiver with a 2-flop synchroniser
// and a transmitter with a valid/ready byte handshake.
module uart_byte
  import uart_ram_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic          rx_m, rx_s, rx_prev;
  bit_state_t    rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_tick;

  bit_state_t    tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;
  logic          tx_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  // The start bit is timed to its midpoint; every later bit is one full period on.
  assign rx_tick = (rx_cnt == ((rx_state == BIT_START) ? HALF : FULL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= BIT_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      BIT_IDLE:  if (rx_prev && !rx_s) rx_next = BIT_START;
      BIT_START: if (rx_tick) rx_next = rx_s ? BIT_IDLE : BIT_DATA;
      BIT_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = BIT_STOP;
      BIT_STOP:  if (rx_tick) rx_next = BIT_IDLE;
      default:   rx_next = BIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      if (rx_state == BIT_IDLE || rx_tick) rx_cnt <= '0;
      else                                 rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == BIT_IDLE) begin
        rx_bit <= '0;
      end else if (rx_state == BIT_DATA && rx_tick) begin
        rx_sh  <= {rx_s, rx_sh[7:1]};
        rx_bit <= rx_bit + 1'b1;
      end
    end
  end

  assign rx_data      = rx_sh;
  assign rx_valid     = (rx_state == BIT_STOP) && rx_tick && rx_s;
  assign rx_frame_err = (rx_state == BIT_STOP) && rx_tick && !rx_s;
  assign rx_busy      = (rx_state != BIT_IDLE);

  assign tx_tick = (tx_cnt == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= BIT_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      BIT_IDLE:  if (tx_valid) tx_next = BIT_START;
      BIT_START: if (tx_tick) tx_next = BIT_DATA;
      BIT_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = BIT_STOP;
      BIT_STOP:  if (tx_tick) tx_next = BIT_IDLE;
      default:   tx_next = BIT_IDLE;
    endcase
  end

  // The line is registered so each bit changes exactly on a bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx     <= 1'b1;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else begin
      case (tx_state)
        BIT_IDLE: begin
          tx_cnt <= '0;
          tx_bit <= '0;
          if (tx_valid) begin
            tx_sh <= tx_data;
            tx    <= 1'b0;
          end else begin
            tx    <= 1'b1;
          end
        end
        BIT_START: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            tx     <= tx_sh[0];
            tx_sh  <= {1'b0, tx_sh[7:1]};
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        BIT_DATA: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            tx_bit <= tx_bit + 1'b1;
            tx     <= (tx_bit == 3'd7) ? 1'b1 : tx_sh[0];
            tx_sh  <= {1'b0, tx_sh[7:1]};
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        BIT_STOP: begin
          if (tx_tick) tx_cnt <= '0;
          else         tx_cnt <= tx_cnt + 1'b1;
        end
        default: tx <= 1'b1;
      endcase
    end
  end

  assign tx_ready = (tx_state == BIT_IDLE);
  assign tx_busy  = (tx_state != BIT_IDLE);

endmodule

// File: rtl/uart_ram_ctrl.sv
// UART-accessible RAM with single/burst read and write commands, write protect,
// inter-byte timeout and sticky error LEDs.
module uart_ram_ctrl
  import uart_ram_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic       wp,
  output logic [4:0] led
);

  localparam int NB  = nbytes(DATA_W);
  localparam int NA  = nbytes(ADDR_W);
  localparam int NB8 = NB * 8;
  localparam logic [1:0] NB_LAST = 2'(NB - 1);
  localparam logic [1:0] NA_LAST = 2'(NA - 1);
  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);

  logic [7:0]        rx_data;
  logic              rx_valid, rx_frame_err, rx_busy;
  logic [7:0]        tx_byte;
  logic              tx_valid, tx_ready, tx_busy;

  state_t            state, next_state;
  op_t               cmd_op;
  logic [5:0]        word_cnt;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [NB8-1:0]    rd_sh;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [TW-1:0]     to_cnt;
  logic              waiting, to_expired, mem_we, blocked;
  logic              err_frame, err_to, err_wp;

  uart_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy),
    .tx_data      (tx_byte),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx           (tx),
    .tx_busy      (tx_busy)
  );

  // The timeout only runs while waiting for a start bit inside a command.
  assign waiting    = (state == ST_ADDR || state == ST_WDATA) && !rx_busy;
  assign to_expired = waiting && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          to_cnt <= '0;
    else if (waiting) to_cnt <= to_cnt + 1'b1;
    else              to_cnt <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    tx_valid   = 1'b0;
    tx_byte    = 8'h00;
    mem_we     = 1'b0;
    case (state)
      ST_IDLE:  if (rx_valid) next_state = ST_CMD;
      ST_CMD:   next_state = (cmd_op == OP_WRITE || cmd_op == OP_READ) ? ST_ADDR : ST_IDLE;
      ST_ADDR: begin
        if (to_expired)
          next_state = ST_IDLE;
        else if (rx_valid && byte_cnt == NA_LAST)
          next_state = (cmd_op == OP_WRITE) ? ST_WDATA : ST_RD;
      end
      ST_WDATA: begin
        if (to_expired)
          next_state = ST_IDLE;
        else if (rx_valid && byte_cnt == NB_LAST)
          next_state = ST_WR;
      end
      ST_WR: begin
        mem_we     = !wp;
        next_state = (word_cnt == 6'd0) ? ST_ACK : ST_WDATA;
      end
      ST_ACK: begin
        tx_valid = 1'b1;
        tx_byte  = blocked ? NAK_BYTE : ACK_BYTE;
        if (tx_ready) next_state = ST_IDLE;
      end
      ST_RD:    next_state = ST_TXW;
      ST_TXW: begin
        tx_valid = 1'b1;
        tx_byte  = rd_sh[NB8-1 -: 8];
        if (tx_ready && byte_cnt == NB_LAST)
          next_state = (word_cnt == 6'd0) ? ST_IDLE : ST_RD;
      end
      default:  next_state = ST_IDLE;
    endcase
  end

  // Address and data fields arrive MSB-first, so shifting in bytes and keeping
  // the low bits naturally discards the unused upper bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_op    <= OP_NOP;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      addr      <= '0;
      wdata     <= '0;
      blocked   <= 1'b0;
      err_frame <= 1'b0;
      err_to    <= 1'b0;
      err_wp    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          byte_cnt <= '0;
          blocked  <= 1'b0;
          if (rx_valid) begin
            cmd_op   <= op_t'(rx_data[7:6]);
            word_cnt <= rx_data[5:0];
          end
        end
        ST_CMD: begin
          if (cmd_op == OP_NOP) begin
            err_frame <= 1'b0;
            err_to    <= 1'b0;
            err_wp    <= 1'b0;
          end
        end
        ST_ADDR: begin
          if (to_expired) begin
            err_to <= 1'b1;
          end else if (rx_valid) begin
            addr     <= ADDR_W'({addr, rx_data});
            byte_cnt <= (byte_cnt == NA_LAST) ? 2'd0 : byte_cnt + 1'b1;
          end
        end
        ST_WDATA: begin
          if (to_expired) begin
            err_to <= 1'b1;
          end else if (rx_valid) begin
            wdata    <= DATA_W'({wdata, rx_data});
            byte_cnt <= (byte_cnt == NB_LAST) ? 2'd0 : byte_cnt + 1'b1;
          end
        end
        ST_WR: begin
          addr     <= addr + 1'b1;
          word_cnt <= word_cnt - 1'b1;
          if (wp) begin
            blocked <= 1'b1;
            err_wp  <= 1'b1;
          end
        end
        ST_RD: begin
          addr     <= addr + 1'b1;
          byte_cnt <= '0;
        end
        ST_TXW: begin
          if (tx_ready) begin
            byte_cnt <= (byte_cnt == NB_LAST) ? 2'd0 : byte_cnt + 1'b1;
            if (byte_cnt == NB_LAST) word_cnt <= word_cnt - 1'b1;
          end
        end
        default: ;
      endcase
      if (rx_frame_err) err_frame <= 1'b1;
    end
  end

  // RAM contents deliberately survive reset, so this array has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= wdata;
    if (state == ST_RD)
      rd_sh <= NB8'(mem[addr]);
    else if (state == ST_TXW && tx_ready)
      rd_sh <= rd_sh << 8;
  end

  assign led = {tx_busy, err_wp, err_to, err_frame, state != ST_IDLE};

endmodule
